// File: rtl/mul_reservation_station_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_reservation_station_pkg
//  Brief    : Core-wide widths, reserved tag value and the reservation
//             station entry layout shared by the multiply issue logic.
//  Revision : 1.0 - initial release
// ============================================================================
package mul_reservation_station_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int TAG_WIDTH  = 6;

   // Tag 0 means "no op" on the issue port and "no broadcast" on the CDB
   localparam logic [TAG_WIDTH-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic                  rdy;
      logic [DATA_WIDTH-1:0] val;
      logic [TAG_WIDTH-1:0]  tag;
   } rs_src_t;

   typedef struct packed {
      logic                 busy;
      logic [TAG_WIDTH-1:0] dest_tag;
      rs_src_t              src1;
      rs_src_t              src2;
   } rs_entry_t;

   // A pending source picks up the broadcast when its producer tag is on the CDB
   function automatic logic src_hit(input logic                 rdy,
                                    input logic [TAG_WIDTH-1:0] tag,
                                    input logic [TAG_WIDTH-1:0] cdb_tag);
      return !rdy && (cdb_tag != TAG_NONE) && (tag == cdb_tag);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_rs_entry.sv
`default_nettype none
// ============================================================================
//  Module   : mul_rs_entry
//  Brief    : One reservation station slot: holds a multiply op, snoops the
//             CDB for its pending sources and reports when fully ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_rs_entry
   import mul_reservation_station_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  alloc,
   input  logic                  issue,
   input  logic [TAG_WIDTH-1:0]  disp_dest_tag,
   input  logic                  disp_src1_rdy,
   input  logic [DATA_WIDTH-1:0] disp_src1_val,
   input  logic [TAG_WIDTH-1:0]  disp_src1_tag,
   input  logic                  disp_src2_rdy,
   input  logic [DATA_WIDTH-1:0] disp_src2_val,
   input  logic [TAG_WIDTH-1:0]  disp_src2_tag,
   input  logic [TAG_WIDTH-1:0]  cdb_tag,
   input  logic [DATA_WIDTH-1:0] cdb_data,
   output logic                  busy,
   output logic                  ready,
   output logic [TAG_WIDTH-1:0]  dest_tag,
   output logic [DATA_WIDTH-1:0] op1,
   output logic [DATA_WIDTH-1:0] op2
);

   rs_entry_t r_ent;

   logic w_byp1;
   logic w_byp2;
   logic w_cap1;
   logic w_cap2;

   // Bypass covers a source whose producer broadcasts in the dispatch cycle
   assign w_byp1 = src_hit(disp_src1_rdy, disp_src1_tag, cdb_tag);
   assign w_byp2 = src_hit(disp_src2_rdy, disp_src2_tag, cdb_tag);
   assign w_cap1 = r_ent.busy && src_hit(r_ent.src1.rdy, r_ent.src1.tag, cdb_tag);
   assign w_cap2 = r_ent.busy && src_hit(r_ent.src2.rdy, r_ent.src2.tag, cdb_tag);

   // Slot storage: alloc and issue never coincide (alloc only targets free slots)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ent <= '0;
      end else if (flush || issue) begin
         r_ent <= '0;
      end else if (alloc) begin
         r_ent.busy      <= 1'b1;
         r_ent.dest_tag  <= disp_dest_tag;
         r_ent.src1.rdy  <= disp_src1_rdy | w_byp1;
         r_ent.src1.val  <= w_byp1 ? cdb_data : disp_src1_val;
         r_ent.src1.tag  <= disp_src1_tag;
         r_ent.src2.rdy  <= disp_src2_rdy | w_byp2;
         r_ent.src2.val  <= w_byp2 ? cdb_data : disp_src2_val;
         r_ent.src2.tag  <= disp_src2_tag;
      end else begin
         if (w_cap1) begin
            r_ent.src1.rdy <= 1'b1;
            r_ent.src1.val <= cdb_data;
         end
         if (w_cap2) begin
            r_ent.src2.rdy <= 1'b1;
            r_ent.src2.val <= cdb_data;
         end
      end
   end

   // Readiness is taken from registered state, so a capture this cycle
   // only makes the slot selectable from the next cycle on
   assign busy     = r_ent.busy;
   assign ready    = r_ent.busy && r_ent.src1.rdy && r_ent.src2.rdy;
   assign dest_tag = r_ent.dest_tag;
   assign op1      = r_ent.src1.val;
   assign op2      = r_ent.src2.val;

endmodule
`default_nettype wire

// File: rtl/mul_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : mul_reservation_station
//  Brief    : Reservation station and single-issue scheduler feeding the
//             pipelined multiplier; lowest-index allocation and selection.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_reservation_station
   import mul_reservation_station_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   // Widths are core-wide; entry storage is laid out with the package values
   parameter int DATA_WIDTH  = mul_reservation_station_pkg::DATA_WIDTH,
   parameter int TAG_WIDTH   = mul_reservation_station_pkg::TAG_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic                             disp_valid,
   output logic                             disp_ready,
   input  logic [TAG_WIDTH-1:0]             disp_dest_tag,
   input  logic                             disp_src1_rdy,
   input  logic [DATA_WIDTH-1:0]            disp_src1_val,
   input  logic [TAG_WIDTH-1:0]             disp_src1_tag,
   input  logic                             disp_src2_rdy,
   input  logic [DATA_WIDTH-1:0]            disp_src2_val,
   input  logic [TAG_WIDTH-1:0]             disp_src2_tag,
   input  logic [TAG_WIDTH-1:0]             cdb_tag,
   input  logic [DATA_WIDTH-1:0]            cdb_data,
   output logic [DATA_WIDTH-1:0]            mul_op1,
   output logic [DATA_WIDTH-1:0]            mul_op2,
   output logic [TAG_WIDTH-1:0]             mul_tag,
   output logic [$clog2(NUM_ENTRIES):0]     occupancy
);

   localparam int c_OCC_W = $clog2(NUM_ENTRIES) + 1;

   logic [NUM_ENTRIES-1:0] w_busy;
   logic [NUM_ENTRIES-1:0] w_ready;
   logic [NUM_ENTRIES-1:0] w_alloc_oh;
   logic [NUM_ENTRIES-1:0] w_sel_oh;
   logic [NUM_ENTRIES-1:0] w_issue;
   logic                   w_alloc_found;
   logic                   w_sel_found;
   logic                   w_disp_fire;

   logic [TAG_WIDTH-1:0]   w_ent_tag [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0]  w_ent_op1 [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0]  w_ent_op2 [NUM_ENTRIES];

   logic [TAG_WIDTH-1:0]   w_sel_tag;
   logic [DATA_WIDTH-1:0]  w_sel_op1;
   logic [DATA_WIDTH-1:0]  w_sel_op2;

   logic [TAG_WIDTH-1:0]   r_mul_tag;
   logic [DATA_WIDTH-1:0]  r_mul_op1;
   logic [DATA_WIDTH-1:0]  r_mul_op2;
   logic [c_OCC_W-1:0]     r_occ;

   assign disp_ready  = ~&w_busy;
   assign w_disp_fire = disp_valid && disp_ready && !flush;
   assign w_issue     = w_sel_oh;

   // Lowest-index free slot gets the dispatch; lowest-index ready slot issues
   always_comb begin
      w_alloc_oh    = '0;
      w_alloc_found = 1'b0;
      w_sel_oh      = '0;
      w_sel_found   = 1'b0;
      w_sel_tag     = '0;
      w_sel_op1     = '0;
      w_sel_op2     = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!w_busy[i] && !w_alloc_found) begin
            w_alloc_oh[i] = 1'b1;
            w_alloc_found = 1'b1;
         end
         if (w_ready[i] && !w_sel_found) begin
            w_sel_oh[i] = 1'b1;
            w_sel_found = 1'b1;
            w_sel_tag   = w_ent_tag[i];
            w_sel_op1   = w_ent_op1[i];
            w_sel_op2   = w_ent_op2[i];
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
         mul_rs_entry u_entry (
            .clk           (clk),
            .reset         (reset),
            .flush         (flush),
            .alloc         (w_disp_fire && w_alloc_oh[g]),
            .issue         (w_issue[g]),
            .disp_dest_tag (disp_dest_tag),
            .disp_src1_rdy (disp_src1_rdy),
            .disp_src1_val (disp_src1_val),
            .disp_src1_tag (disp_src1_tag),
            .disp_src2_rdy (disp_src2_rdy),
            .disp_src2_val (disp_src2_val),
            .disp_src2_tag (disp_src2_tag),
            .cdb_tag       (cdb_tag),
            .cdb_data      (cdb_data),
            .busy          (w_busy[g]),
            .ready         (w_ready[g]),
            .dest_tag      (w_ent_tag[g]),
            .op1           (w_ent_op1[g]),
            .op2           (w_ent_op2[g])
         );
      end
   endgenerate

   // Issue register: bubble (tag 0, zero operands) whenever nothing is ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mul_tag <= '0;
         r_mul_op1 <= '0;
         r_mul_op2 <= '0;
      end else if (flush) begin
         r_mul_tag <= '0;
         r_mul_op1 <= '0;
         r_mul_op2 <= '0;
      end else begin
         r_mul_tag <= w_sel_tag;
         r_mul_op1 <= w_sel_op1;
         r_mul_op2 <= w_sel_op2;
      end
   end

   // Busy-entry count: +1 per accepted dispatch, -1 per issue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_occ <= '0;
      end else if (flush) begin
         r_occ <= '0;
      end else begin
         r_occ <= r_occ + c_OCC_W'(w_disp_fire) - c_OCC_W'(w_sel_found);
      end
   end

   assign mul_tag   = r_mul_tag;
   assign mul_op1   = r_mul_op1;
   assign mul_op2   = r_mul_op2;
   assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_mul_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_reservation_station
//  Brief    : Directed self-checking bench for mul_reservation_station.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_reservation_station;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic [5:0]  disp_dest_tag;
   logic        disp_src1_rdy;
   logic [31:0] disp_src1_val;
   logic [5:0]  disp_src1_tag;
   logic        disp_src2_rdy;
   logic [31:0] disp_src2_val;
   logic [5:0]  disp_src2_tag;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [31:0] mul_op1;
   logic [31:0] mul_op2;
   logic [5:0]  mul_tag;
   logic [2:0]  occupancy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [5:0]  dest;
      logic        s1_rdy;
      logic [31:0] s1_val;
      logic [5:0]  s1_tag;
      logic        s2_rdy;
      logic [31:0] s2_val;
      logic [5:0]  s2_tag;
      logic [5:0]  cdb_t;
      logic [31:0] cdb_d;
      logic [31:0] exp_op1;
      logic [31:0] exp_op2;
   } vec_t;

   vec_t vecs [5];

   mul_reservation_station dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .disp_valid    (disp_valid),
      .disp_ready    (disp_ready),
      .disp_dest_tag (disp_dest_tag),
      .disp_src1_rdy (disp_src1_rdy),
      .disp_src1_val (disp_src1_val),
      .disp_src1_tag (disp_src1_tag),
      .disp_src2_rdy (disp_src2_rdy),
      .disp_src2_val (disp_src2_val),
      .disp_src2_tag (disp_src2_tag),
      .cdb_tag       (cdb_tag),
      .cdb_data      (cdb_data),
      .mul_op1       (mul_op1),
      .mul_op2       (mul_op2),
      .mul_tag       (mul_tag),
      .occupancy     (occupancy)
   );

   always #5 clk = ~clk;

   // Accepted dispatches must carry a real destination tag
   always @(posedge clk) begin
      if (reset && disp_valid && disp_ready && !flush)
         assert (disp_dest_tag != 6'd0) else $error("dispatch with destination tag 0");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [5:0] dest,
                       input logic s1r, input logic [31:0] s1v, input logic [5:0] s1t,
                       input logic s2r, input logic [31:0] s2v, input logic [5:0] s2t);
      disp_valid    = 1'b1;
      disp_dest_tag = dest;
      disp_src1_rdy = s1r;
      disp_src1_val = s1v;
      disp_src1_tag = s1t;
      disp_src2_rdy = s2r;
      disp_src2_val = s2v;
      disp_src2_tag = s2t;
   endtask

   initial begin
      // dest, s1 rdy/val/tag, s2 rdy/val/tag, cdb tag/data, expected op1/op2
      vecs[0] = '{6'd5,  1'b1, 32'd3,        6'd0,  1'b1, 32'd7,  6'd0,  6'd0,  32'd0,        32'd3,        32'd7};
      vecs[1] = '{6'd21, 1'b0, 32'd0,        6'd20, 1'b1, 32'd9,  6'd0,  6'd20, 32'd11,       32'd11,       32'd9};
      vecs[2] = '{6'd33, 1'b1, 32'hFFFFFFFF, 6'd0,  1'b0, 32'd0,  6'd20, 6'd20, 32'd11,       32'hFFFFFFFF, 32'd11};
      vecs[3] = '{6'd63, 1'b0, 32'd0,        6'd7,  1'b0, 32'd0,  6'd7,  6'd7,  32'h12345678, 32'h12345678, 32'h12345678};
      vecs[4] = '{6'd2,  1'b1, 32'd100,      6'd4,  1'b1, 32'd1,  6'd0,  6'd4,  32'd55,       32'd100,      32'd1};

      reset = 1'b0;
      flush = 1'b0;
      disp(6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0);
      disp_valid = 1'b0;
      cdb_tag  = 6'd0;
      cdb_data = 32'd0;

      // Reset state
      step();
      step();
      check("reset_mul_tag", 64'(mul_tag), 64'd0);
      check("reset_occ", 64'(occupancy), 64'd0);
      reset = 1'b1;
      step();
      check("reset_disp_ready", 64'(disp_ready), 64'd1);
      check("reset_mul_op1", 64'(mul_op1), 64'd0);

      // Table: single dispatch, possibly with same-cycle bypass, issues 2 edges later
      for (int i = 0; i < 5; i++) begin
         disp(vecs[i].dest, vecs[i].s1_rdy, vecs[i].s1_val, vecs[i].s1_tag,
              vecs[i].s2_rdy, vecs[i].s2_val, vecs[i].s2_tag);
         cdb_tag  = vecs[i].cdb_t;
         cdb_data = vecs[i].cdb_d;
         step();
         disp_valid = 1'b0;
         cdb_tag    = 6'd0;
         cdb_data   = 32'd0;
         check($sformatf("v%0d_tag_e1", i), 64'(mul_tag), 64'd0);
         check($sformatf("v%0d_occ_e1", i), 64'(occupancy), 64'd1);
         step();
         check($sformatf("v%0d_op1", i), 64'(mul_op1), 64'(vecs[i].exp_op1));
         check($sformatf("v%0d_op2", i), 64'(mul_op2), 64'(vecs[i].exp_op2));
         check($sformatf("v%0d_tag", i), 64'(mul_tag), 64'(vecs[i].dest));
         check($sformatf("v%0d_occ_e2", i), 64'(occupancy), 64'd0);
      end

      // CDB wakeup after idle cycles
      disp(6'd9, 1'b0, 32'd0, 6'd12, 1'b1, 32'd4, 6'd0);
      step();
      disp_valid = 1'b0;
      check("wake_occ", 64'(occupancy), 64'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("wake_idle%0d_tag", k), 64'(mul_tag), 64'd0);
      end
      cdb_tag  = 6'd12;
      cdb_data = 32'd6;
      step();
      cdb_tag  = 6'd0;
      cdb_data = 32'd0;
      check("wake_capture_tag", 64'(mul_tag), 64'd0);
      step();
      check("wake_op1", 64'(mul_op1), 64'd6);
      check("wake_op2", 64'(mul_op2), 64'd4);
      check("wake_tag", 64'(mul_tag), 64'd9);
      check("wake_occ_end", 64'(occupancy), 64'd0);

      // Fill all entries with unresolved sources
      for (int k = 0; k < 4; k++) begin
         disp(6'(10 + k), 1'b0, 32'd0, 6'(40 + k), 1'b1, 32'(k + 1), 6'd0);
         step();
      end
      check("full_ready", 64'(disp_ready), 64'd0);
      check("full_occ", 64'(occupancy), 64'd4);
      check("full_tag", 64'(mul_tag), 64'd0);
      disp(6'd14, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0);
      step();
      disp_valid = 1'b0;
      check("full_ignore_occ", 64'(occupancy), 64'd4);
      cdb_tag  = 6'd42;
      cdb_data = 32'hAA;
      step();
      cdb_tag  = 6'd0;
      cdb_data = 32'd0;
      check("e2_capture_tag", 64'(mul_tag), 64'd0);
      check("e2_capture_ready", 64'(disp_ready), 64'd0);
      step();
      check("e2_tag", 64'(mul_tag), 64'd12);
      check("e2_op1", 64'(mul_op1), 64'hAA);
      check("e2_op2", 64'(mul_op2), 64'd3);
      check("e2_occ", 64'(occupancy), 64'd3);
      check("e2_ready", 64'(disp_ready), 64'd1);

      // Flush with 3 busy entries and a concurrent dispatch
      flush = 1'b1;
      disp(6'd50, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0);
      step();
      flush      = 1'b0;
      disp_valid = 1'b0;
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_tag", 64'(mul_tag), 64'd0);
      check("flush_ready", 64'(disp_ready), 64'd1);
      step();
      check("flush_no_issue", 64'(mul_tag), 64'd0);
      cdb_tag  = 6'd40;
      cdb_data = 32'd77;
      step();
      cdb_tag  = 6'd0;
      cdb_data = 32'd0;
      step();
      check("stale_tag", 64'(mul_tag), 64'd0);
      check("stale_occ", 64'(occupancy), 64'd0);

      // Entries 1 and 3 wait on the same producer and wake together
      for (int k = 0; k < 4; k++) begin
         disp(6'(20 + k), 1'b0, 32'd0, (k == 3) ? 6'd31 : 6'(30 + k),
              1'b1, (k == 1) ? 32'd5 : ((k == 3) ? 32'd8 : 32'(k + 1)), 6'd0);
         step();
      end
      disp_valid = 1'b0;
      check("pair_occ", 64'(occupancy), 64'd4);
      cdb_tag  = 6'd31;
      cdb_data = 32'd7;
      step();
      cdb_tag  = 6'd0;
      cdb_data = 32'd0;
      check("pair_capture_tag", 64'(mul_tag), 64'd0);
      step();
      check("pair_first_tag", 64'(mul_tag), 64'd21);
      check("pair_first_op1", 64'(mul_op1), 64'd7);
      check("pair_first_op2", 64'(mul_op2), 64'd5);
      step();
      check("pair_second_tag", 64'(mul_tag), 64'd23);
      check("pair_second_op2", 64'(mul_op2), 64'd8);
      check("pair_occ_end", 64'(occupancy), 64'd2);

      // Asynchronous reset mid-operation
      reset = 1'b0;
      #1;
      check("async_tag", 64'(mul_tag), 64'd0);
      check("async_op1", 64'(mul_op1), 64'd0);
      check("async_occ", 64'(occupancy), 64'd0);
      step();
      reset = 1'b1;
      step();
      check("async_ready", 64'(disp_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
